// File: rtl/seq1010_pkg.sv
// Shared types for the time-shared "1010" detector: channel FSM state and its next-state rule.
// Build option: SEQ1010_NONOVERLAP_EN selects non-overlapping detection (S4 restarts from scratch).
package seq1010_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle
    S1 = 3'd1,  // seen "1"
    S2 = 3'd2,  // seen "10"
    S3 = 3'd3,  // seen "101"
    S4 = 3'd4   // seen "1010" (match)
  } state_t;

  function automatic state_t next_state(input state_t cur, input logic in_bit);
    case (cur)
      S0:      return in_bit ? S1 : S0;
      S1:      return in_bit ? S1 : S2;
      S2:      return in_bit ? S3 : S0;
      S3:      return in_bit ? S1 : S4;
`ifdef SEQ1010_NONOVERLAP_EN
      S4:      return in_bit ? S1 : S0;
`else
      S4:      return in_bit ? S3 : S0;
`endif
      default: return S0;
    endcase
  endfunction

endpackage

// File: rtl/seq1010_tdm_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer, wrapping,
// then moves the pointer one past the winner whenever advance is asserted.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic          found;
  int            k;

  // NOTE: combinational blocks use blocking '=' with every output defaulted first,
  // so the search loop reads its own partial results and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[k[IW-1:0]]) begin
        found            = 1'b1;
        gnt[k[IW-1:0]]   = 1'b1;
        gnt_idx          = k[IW-1:0];
      end
    end
  end

  // NOTE: clocked state uses non-blocking '<=' so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/seq1010_tdm_sched.sv
// Time-division "1010" detector: one next-state engine shared by NUM_CH serial channels
// through a round-robin grant. Build option SEQ1010_NONOVERLAP_EN (see seq1010_pkg).
module seq1010_tdm_sched
  import seq1010_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_bit,
  output logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_clr,
  output logic              match_valid,
  output logic [CH_W-1:0]   match_ch,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              any_gnt;

  state_t           st  [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];

  state_t nxt;
  logic   hit;

  // Cleared channels and the whole block under reset never request, so ready stays low.
  assign req     = ch_valid & ~ch_clr & {NUM_CH{rst_n}};
  assign any_gnt = |gnt;
  assign ch_ready = gnt;

  rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (any_gnt),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // The single shared engine: only the granted channel's saved state is advanced.
  always_comb begin
    nxt = next_state(st[gnt_idx], ch_bit[gnt_idx]);
    hit = any_gnt && (nxt == S4);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the state file and counters are small flop arrays, not RAM, so every
      // entry is reset; a mid-stream reset must drop all partial matches.
      for (int i = 0; i < NUM_CH; i++) begin
        st[i]  <= S0;
        cnt[i] <= '0;
      end
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else begin
      match_valid <= hit;
      if (hit) match_ch <= gnt_idx;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_clr[i]) begin
          st[i]  <= S0;
          cnt[i] <= '0;
        end else if (gnt[i]) begin
          st[i] <= nxt;
          if (hit && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_cnt = '0;
    if (int'(rd_ch) < NUM_CH) rd_cnt = cnt[rd_ch];
  end

endmodule

// File: tb/tb_seq1010_tdm_sched.sv
// Scoreboard bench for seq1010_tdm_sched: a bit-history reference model predicts grants,
// matches and counters; a monitor pops expectations as the DUT presents results.
module tb_seq1010_tdm_sched;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX_M = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] ch_valid, ch_bit, ch_clr, ch_ready;
  logic              match_valid;
  logic [CH_W-1:0]   match_ch, rd_ch;
  logic [CNT_W-1:0]  rd_cnt;

  seq1010_tdm_sched #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_valid    (ch_valid),
    .ch_bit      (ch_bit),
    .ch_ready    (ch_ready),
    .ch_clr      (ch_clr),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .rd_ch       (rd_ch),
    .rd_cnt      (rd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int ch;
  } match_t;

  match_t exp_q[$];
  int     cnt_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: the last four consumed bits per channel and how many are valid.
  int       ptr_m;
  bit [3:0] hist_m [NUM_CH];
  int       nb_m   [NUM_CH];
  int       cnt_m  [NUM_CH];
  int       drv_cyc = 0;
  bit       started = 0;

  logic [CNT_W-1:0]  last_cnt;
  logic [NUM_CH-1:0] last_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ptr_m = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      hist_m[i] = '0;
      nb_m[i]   = 0;
      cnt_m[i]  = 0;
    end
  endtask

  task automatic cycle(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] b,
                       input logic [NUM_CH-1:0] c, input int rd, input logic rst);
    int     g;
    match_t m;
    logic [NUM_CH-1:0] exp_rdy;
    @(negedge clk);
    ch_valid = v;
    ch_bit   = b;
    ch_clr   = c;
    rd_ch    = CH_W'(rd);
    rst_n    = rst;
    #1;
    last_cnt = rd_cnt;
    last_rdy = ch_ready;
    g = -1;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        int idx;
        idx = (ptr_m + i) % NUM_CH;
        if (g < 0 && v[idx] && !c[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("ch_ready", 32'(ch_ready), 32'(exp_rdy));

    if (!rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (c[i]) begin
          hist_m[i] = '0;
          nb_m[i]   = 0;
          cnt_m[i]  = 0;
        end
      end
      if (g >= 0) begin
        hist_m[g] = {hist_m[g][2:0], b[g]};
        if (nb_m[g] < 4) nb_m[g]++;
        if (nb_m[g] >= 4 && hist_m[g] == 4'b1010) begin
          m.cyc = drv_cyc;
          m.ch  = g;
          exp_q.push_back(m);
          if (cnt_m[g] < CNT_MAX_M) cnt_m[g]++;
`ifdef SEQ1010_NONOVERLAP_EN
          nb_m[g] = 0;
`endif
        end
        ptr_m = (g + 1) % NUM_CH;
      end
    end
    cnt_q.push_back(cnt_m[rd]);
    drv_cyc++;
    started = 1;
  endtask

  task automatic do_reset();
    cycle('0, '0, '0, 0, 1'b0);
  endtask

  task automatic stream(input int ch, input logic [31:0] pat, input int len);
    logic [NUM_CH-1:0] v, b;
    for (int i = len - 1; i >= 0; i--) begin
      v = '0;
      b = '0;
      v[ch] = 1'b1;
      b[ch] = pat[i];
      cycle(v, b, '0, 0, 1'b1);
    end
  endtask

  task automatic peek(input string name, input int ch, input int exp);
    cycle('0, '0, '0, ch, 1'b1);
    check(name, 32'(last_cnt), exp);
  endtask

  // Monitor: one sample per clock edge, popping whatever the driver predicted for it.
  initial begin : monitor
    int     mon_cyc;
    bit     exp_now;
    match_t m;
    mon_cyc = 0;
    wait (started);
    forever begin
      @(posedge clk);
      #2;
      if (mon_cyc < drv_cyc) begin
        exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == mon_cyc);
        check("match_valid", 32'(match_valid), 32'(exp_now));
        if (exp_now) begin
          m = exp_q.pop_front();
          if (match_valid) check("match_ch", 32'(match_ch), m.ch);
        end
        if (cnt_q.size() > 0) check("rd_cnt", 32'(rd_cnt), cnt_q.pop_front());
        mon_cyc++;
      end
    end
  end

  initial begin : driver
    logic [NUM_CH-1:0] v, b, c;
    logic [31:0]       pat;
    ch_valid = '0;
    ch_bit   = '0;
    ch_clr   = '0;
    rd_ch    = '0;
    rst_n    = 1'b0;
    model_reset();

    do_reset();
    do_reset();
    check("reset_ready", 32'(last_rdy), 0);
    check("reset_cnt", 32'(last_cnt), 0);

    // Single channel 0 detection
    stream(0, 32'b1010, 4);
    peek("single_cnt0", 0, 1);

    // Overlapping detection on channel 1
    stream(1, 32'b101010, 6);
`ifdef SEQ1010_NONOVERLAP_EN
    peek("overlap_cnt1", 1, 1);
`else
    peek("overlap_cnt1", 1, 2);
`endif

    // Fairness: all channels requesting, each fed 1010 interleaved
    do_reset();
    pat = 32'b1010;
    for (int r = 3; r >= 0; r--)
      for (int j = 0; j < NUM_CH; j++)
        cycle('1, {NUM_CH{pat[r]}}, '0, 0, 1'b1);
    for (int ch = 0; ch < NUM_CH; ch++) peek("fair_cnt", ch, 1);

    // Clear collides with a would-be match on channel 2; channel 3 still granted
    do_reset();
    stream(2, 32'b101, 3);
    cycle(4'b1100, 4'b0000, 4'b0100, 0, 1'b1);
    check("clr_ready2", 32'(last_rdy[2]), 0);
    check("clr_ready3", 32'(last_rdy[3]), 1);
    peek("clr_cnt2", 2, 0);
    stream(2, 32'b0, 1);

    // Counter saturation at 2^CNT_W-1
    do_reset();
    stream(0, 32'b1010_1010_1010_1010_1010, 20);
    peek("sat_cnt0", 0, 3);

    // Reset in the middle of a partial match
    do_reset();
    stream(0, 32'b101, 3);
    do_reset();
    stream(0, 32'b0, 1);
    peek("rst_mid_cnt0", 0, 0);

    // Randomized traffic with occasional clears and resets
    for (int n = 0; n < 1500; n++) begin
      v = NUM_CH'($urandom);
      b = NUM_CH'($urandom);
      c = ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0;
      cycle(v, b, c, $urandom_range(0, NUM_CH - 1), ($urandom_range(0, 199) != 0));
    end

    cycle('0, '0, '0, 0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("cnt_q_drained", cnt_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq1010_tdm_sched.md
Name: seq1010_tdm_sched

Overview:
Time-division scheduler sharing one Moore "1010" detector engine among NUM_CH serial bit-stream channels. A round-robin arbiter grants at most one requesting channel per clock. The granted bit advances that channel's saved FSM state in a per-channel state file. Matches are reported as a tagged pulse and counted per channel. Sits between the serial front-ends and the event/status logic.

Parameters:
NUM_CH, 4, number of serial channels (2..16)
CH_W, 2, channel index width, equal to $clog2(NUM_CH)
CNT_W, 8, per-channel saturating match-counter width

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
ch_valid  in  NUM_CH  channel i presents a bit
ch_bit  in  NUM_CH  bit value for channel i
ch_ready  out  NUM_CH  one-hot grant; a bit is consumed when valid & ready
ch_clr  in  NUM_CH  synchronous clear of channel i state and counter
match_valid  out  1  one-cycle pulse: a channel completed 1010
match_ch  out  CH_W  channel index for match_valid
rd_ch  in  CH_W  counter read select
rd_cnt  out  CNT_W  match count of rd_ch, combinational read

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All channel states go to S0, all counters to 0, round-robin pointer to 0.
  - match_valid=0, match_ch=0.
  - ch_ready is 0 during reset.
- Channel state encoding is 3 bits:
  - S0 idle, S1 "1", S2 "10", S3 "101", S4 "1010" (match).
- Overlapping transitions (in=1 / in=0):
  - S0: S1 / S0
  - S1: S1 / S2
  - S2: S3 / S0
  - S3: S1 / S4
  - S4: S3 / S0
  - An illegal encoding goes to S0.
- Arbitration:
  - Request vector is req = ch_valid & ~ch_clr.
  - The grant is the first set req bit searching from ptr upward, wrapping modulo NUM_CH.
  - ch_ready is combinational from req and ptr, one-hot or zero.
  - On a grant to channel g, ptr <= g+1, wrapping NUM_CH-1 to 0. With no grant, ptr holds.
- Engine:
  - On a grant, state[g] <= next(state[g], ch_bit[g]) at the same edge.
  - Ungranted channels hold their state. No bits are buffered.
  - Throughput is one bit per cycle in aggregate. Each channel is guaranteed at least one grant per NUM_CH cycles while requesting.
- Match:
  - If the computed next state is S4, match_valid=1 and match_ch=g in the cycle after the grant (latency 1).
  - In the same edge, cnt[g] increments and saturates at 2^CNT_W-1 (no wrap).
- Clear:
  - ch_clr[i]=1 forces state[i]<=S0 and cnt[i]<=0 at the edge and masks channel i's request (ready=0, bit not consumed).
  - A clear on a channel other than g does not disturb the grant.
- rd_cnt reflects the registered counter, so it shows the incremented value one cycle after the match.
- Reset mid-stream discards all partial matches. The first post-reset grant goes to the lowest requesting index.

Optional Feature:
- Macro: SEQ1010_NONOVERLAP_EN.
- Defined: S4 transitions as a fresh start, in=1 to S1 and in=0 to S0. Non-overlapping detection.
- Undefined: the overlapping table above, where S4 with in=1 goes to S3.

Decomposition:
- Package seq1010_pkg holds:
  - state_t enum (S0..S4, 3-bit) and the next-state function next_state(state_t, logic).
  - The default NUM_CH and CNT_W constants.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, advance.
  - Outputs: one-hot gnt and binary gnt_idx, with the pointer held internally.
- The top level holds the state file, counters and match register.

Test Plan:
- Single channel 0 streams 1,0,1,0 (others idle), one bit per cycle → match_valid=1, match_ch=0 one cycle after the 4th bit; cnt[0]=1.
- Overlap: ch1 streams 1,0,1,0,1,0 → two matches, the second after the 6th bit; cnt[1]=2. With SEQ1010_NONOVERLAP_EN → one match; cnt[1]=1.
- Fairness: all 4 channels valid continuously → grants cycle 0,1,2,3,0… Four channels each fed 1010 interleaved → four matches with match_ch 0,1,2,3 on consecutive cycles.
- Clear collision: ch2 in S3 with ch_clr[2]=1 and ch_valid[2]=1, ch_bit=0 → ch_ready[2]=0, no match, state[2]=S0, cnt[2]=0. ch3 is still granted that cycle.
- Saturation: CNT_W=2, ch0 fed 1010 five times → rd_cnt for rd_ch=0 stays at 3.
- Reset mid-operation: ch0 at S3, rst_n=0 for one cycle, then ch0 sends 0 → no match; state S0. match_valid=0 during and after reset.
